des_wb_regs: RTL and testbench

//  Wishbone-slave register front end of des_top: sits between the Caravel WB port and the DES datapath.

---
 rtl/des_wb_regs.sv | 193 +++++++++++++++++++
 tb/tb_des_wb_regs.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_wb_regs.sv
// Wishbone register front end for the DES core: key/data/control registers, start/done launch FSM, result capture.
// Optional completion interrupt is compiled in when DES_WB_IRQ_EN is defined; otherwise o_irq is tied low.

module des_wb_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_data,
   output logic [63:0] o_des_key,
   output logic [63:0] o_des_data,
   output logic        o_des_decrypt,
   output logic        o_des_start,
   input  logic        i_des_done,
   input  logic [63:0] i_des_result,
   output logic        o_irq,
   output logic [1:0]  dbg_state
);

   localparam logic [7:0] OFF_CTRL    = 8'h00;
   localparam logic [7:0] OFF_STATUS  = 8'h04;
   localparam logic [7:0] OFF_KEY_LO  = 8'h08;
   localparam logic [7:0] OFF_KEY_HI  = 8'h0C;
   localparam logic [7:0] OFF_DIN_LO  = 8'h10;
   localparam logic [7:0] OFF_DIN_HI  = 8'h14;
   localparam logic [7:0] OFF_DOUT_LO = 8'h18;
   localparam logic [7:0] OFF_DOUT_HI = 8'h1C;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] key_lo, key_hi, din_lo, din_hi, dout_lo, dout_hi;
   logic        decrypt;
   logic        done;
   logic        irq_en;
   logic        irq_pend;

   logic        hit, wr, rd, busy;
   logic [7:0]  offset;
   logic        start_req, done_evt, done_w1c, irq_w1c;
   logic [31:0] rdata;

   // Handshake: a request is accepted (hit) when cyc&stb are high inside the window and no ack is
   // outstanding; ack is registered one cycle later and forced low the following cycle, so a held
   // strobe is acknowledged every other cycle. Out-of-window requests are never acknowledged.
   assign hit    = i_wb_cyc & i_wb_stb & (i_wb_addr[31:8] == BASE_ADDR[31:8]) & ~o_wb_ack;
   assign wr     = hit & i_wb_we;
   assign rd     = hit & ~i_wb_we;
   assign offset = i_wb_addr[7:0];
   assign busy   = (state != ST_IDLE);

   assign start_req = wr & (offset == OFF_CTRL) & i_wb_sel[0] & i_wb_data[0] & ~busy;
   assign done_evt  = (state == ST_WAIT) & i_des_done;
   assign done_w1c  = wr & (offset == OFF_STATUS) & i_wb_sel[0] & i_wb_data[1];
   assign irq_w1c   = wr & (offset == OFF_STATUS) & i_wb_sel[0] & i_wb_data[2];

   assign o_des_key     = {key_hi, key_lo};
   assign o_des_data    = {din_hi, din_lo};
   assign o_des_decrypt = decrypt;
   assign dbg_state     = state;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   always_comb begin
      rdata = '0;
      case (offset)
         OFF_CTRL:    rdata = {29'd0, irq_en, decrypt, 1'b0};
         OFF_STATUS:  rdata = {29'd0, irq_pend, done, busy};
         OFF_KEY_LO:  rdata = key_lo;
         OFF_KEY_HI:  rdata = key_hi;
         OFF_DIN_LO:  rdata = din_lo;
         OFF_DIN_HI:  rdata = din_hi;
         OFF_DOUT_LO: rdata = dout_lo;
         OFF_DOUT_HI: rdata = dout_hi;
         default:     rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack  <= hit;
         o_wb_data <= rd ? rdata : '0;
      end
   end

   // Operand and control registers are frozen while an operation is in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_lo  <= '0;
         key_hi  <= '0;
         din_lo  <= '0;
         din_hi  <= '0;
         decrypt <= 1'b0;
      end else if (wr && !busy) begin
         case (offset)
            OFF_KEY_LO: key_lo <= merge_bytes(key_lo, i_wb_data, i_wb_sel);
            OFF_KEY_HI: key_hi <= merge_bytes(key_hi, i_wb_data, i_wb_sel);
            OFF_DIN_LO: din_lo <= merge_bytes(din_lo, i_wb_data, i_wb_sel);
            OFF_DIN_HI: din_hi <= merge_bytes(din_hi, i_wb_data, i_wb_sel);
            OFF_CTRL:   if (i_wb_sel[0]) decrypt <= i_wb_data[1];
            default:    ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         o_des_start <= 1'b0;
         dout_lo     <= '0;
         dout_hi     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               o_des_start <= 1'b0;
               if (start_req) begin
                  state       <= ST_START;
                  o_des_start <= 1'b1;
               end
            end
            ST_START: begin
               o_des_start <= 1'b0;
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
               o_des_start <= 1'b0;
               if (i_des_done) begin
                  dout_lo <= i_des_result[31:0];
                  dout_hi <= i_des_result[63:32];
                  state   <= ST_IDLE;
               end
            end
            default: begin
               o_des_start <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

   // A completion in the same cycle as a W1C keeps the flag set so the event is never lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done <= 1'b0;
      end else if (done_evt) begin
         done <= 1'b1;
      end else if (start_req || done_w1c) begin
         done <= 1'b0;
      end
   end

`ifdef DES_WB_IRQ_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en   <= 1'b0;
         irq_pend <= 1'b0;
      end else begin
         if (wr && !busy && (offset == OFF_CTRL) && i_wb_sel[0]) irq_en <= i_wb_data[2];
         if (done_evt && irq_en) irq_pend <= 1'b1;
         else if (irq_w1c)       irq_pend <= 1'b0;
      end
   end
   assign o_irq = irq_pend;
`else
   assign irq_en   = 1'b0;
   assign irq_pend = 1'b0;
   assign o_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_des_wb_regs.sv
// Self-checking bench for des_wb_regs: bus driver tasks, a behavioural DES-core stand-in and a register model.
// Build with DES_WB_IRQ_EN defined to exercise the interrupt path.

module tb_des_wb_regs;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_wb_cyc, i_wb_stb, i_wb_we;
   logic [3:0]  i_wb_sel;
   logic [31:0] i_wb_addr, i_wb_data;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;
   logic [63:0] o_des_key, o_des_data;
   logic        o_des_decrypt, o_des_start;
   logic        i_des_done;
   logic [63:0] i_des_result;
   logic        o_irq;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   int start_pulses = 0;
   int done_pulses = 0;
   bit auto_core = 1'b1;
   int core_lat = 16;
   logic [63:0] core_result = '0;
   logic [63:0] seen_key, seen_data;
   logic        seen_dec;

   // reference model of the register file
   logic [31:0] m_key_lo, m_key_hi, m_din_lo, m_din_hi, m_dout_lo, m_dout_hi;
   logic        m_dec;
   logic [31:0] exp_q[$];

   des_wb_regs #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_sel(i_wb_sel),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
      .o_des_key(o_des_key), .o_des_data(o_des_data), .o_des_decrypt(o_des_decrypt),
      .o_des_start(o_des_start), .i_des_done(i_des_done), .i_des_result(i_des_result),
      .o_irq(o_irq), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      m_key_lo = '0; m_key_hi = '0; m_din_lo = '0; m_din_hi = '0;
      m_dout_lo = '0; m_dout_hi = '0; m_dec = 1'b0;
   endtask

   // ---------------- DES core stand-in ----------------
   always @(negedge clk) if (o_des_start) start_pulses++;

   initial begin
      i_des_done = 1'b0;
      i_des_result = '0;
      forever begin
         @(negedge clk);
         if (o_des_start && auto_core) begin
            seen_key = o_des_key;
            seen_data = o_des_data;
            seen_dec = o_des_decrypt;
            repeat (core_lat - 1) @(negedge clk);
            i_des_done = 1'b1;
            i_des_result = core_result;
            @(negedge clk);
            i_des_done = 1'b0;
            i_des_result = '0;
            done_pulses++;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, output logic [31:0] rdata, output int lat);
      @(negedge clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
      i_wb_addr = addr; i_wb_data = data; i_wb_sel = sel;
      lat = -1;
      rdata = '0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (o_wb_ack) begin
            lat = i;
            rdata = o_wb_data;
            break;
         end
      end
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      @(posedge clk);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] data, input logic [3:0] sel);
      logic [31:0] d;
      int l;
      wb_xfer(1'b1, BASE | {24'd0, off}, data, sel, d, l);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] data, output int lat);
      wb_xfer(1'b0, BASE | {24'd0, off}, 32'd0, 4'd0, data, lat);
   endtask

   task automatic wait_done(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (done_pulses >= target) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] sel);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
      return r;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] d;
      int l;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({o_wb_ack, o_wb_data, o_des_key, o_des_data, o_des_decrypt, o_des_start, o_irq} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ack=%b data=%h key=%h din=%h dec=%b start=%b irq=%b required all 0",
                  o_wb_ack, o_wb_data, o_des_key, o_des_data, o_des_decrypt, o_des_start, o_irq);
      end
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         rd(8'(k * 4), d, l);
         checks++;
         if (d !== 32'h0 || l !== 1) begin
            errors++;
            $display("FAIL reset_read off=%0h: got data=%h lat=%0d required 00000000 lat=1", k * 4, d, l);
         end
      end
   endtask

   task automatic test_des_vector();
      logic [31:0] d;
      int l, p0, target;
      bit ok;
      wr(8'h08, 32'h9BBCDFF1, 4'hF); m_key_lo = 32'h9BBCDFF1;
      wr(8'h0C, 32'h13345779, 4'hF); m_key_hi = 32'h13345779;
      wr(8'h10, 32'h89ABCDEF, 4'hF); m_din_lo = 32'h89ABCDEF;
      wr(8'h14, 32'h01234567, 4'hF); m_din_hi = 32'h01234567;
      core_result = 64'h85E813540F0AB405;
      core_lat = 16;
      p0 = start_pulses;
      target = done_pulses + 1;
      wr(8'h00, 32'h1, 4'hF);
      rd(8'h04, d, l);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL vec_busy: got %h required 00000001", d); end
      wait_done(target, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec_done_timeout: got no completion required completion"); end
      checks++;
      if (seen_key !== 64'h133457799BBCDFF1 || seen_data !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL vec_operands: got key=%h din=%h required 133457799bbcdff1/0123456789abcdef", seen_key, seen_data);
      end
      rd(8'h04, d, l);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL vec_status: got %h required 00000002", d); end
      rd(8'h18, d, l);
      checks++;
      if (d !== 32'h0F0AB405) begin errors++; $display("FAIL vec_dout_lo: got %h required 0f0ab405", d); end
      rd(8'h1C, d, l);
      checks++;
      if (d !== 32'h85E81354) begin errors++; $display("FAIL vec_dout_hi: got %h required 85e81354", d); end
      checks++;
      if (start_pulses - p0 !== 1) begin
         errors++; $display("FAIL vec_start_count: got %0d required 1", start_pulses - p0);
      end
      m_dout_lo = 32'h0F0AB405; m_dout_hi = 32'h85E81354;
   endtask

   task automatic test_busy_ignore();
      logic [31:0] d;
      int l, p0, target;
      bit ok;
      core_lat = 24;
      core_result = 64'hA5A5_0000_1234_5678;
      p0 = start_pulses;
      target = done_pulses + 1;
      wr(8'h00, 32'h1, 4'hF);
      wr(8'h08, 32'hFFFFFFFF, 4'hF);
      wr(8'h00, 32'h3, 4'hF);
      rd(8'h08, d, l);
      checks++;
      if (d !== m_key_lo) begin errors++; $display("FAIL busy_key_lo: got %h required %h", d, m_key_lo); end
      rd(8'h00, d, l);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL busy_ctrl: got %h required 00000000", d); end
      rd(8'h04, d, l);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL busy_status: got %h required 00000001", d); end
      wait_done(target, ok);
      repeat (10) @(negedge clk);
      checks++;
      if (!ok || start_pulses - p0 !== 1 || o_des_decrypt !== 1'b0) begin
         errors++;
         $display("FAIL busy_single_start: got done=%b starts=%0d dec=%b required 1/1/0",
                  ok, start_pulses - p0, o_des_decrypt);
      end
      m_dout_lo = core_result[31:0]; m_dout_hi = core_result[63:32];
      rd(8'h18, d, l);
      checks++;
      if (d !== m_dout_lo) begin errors++; $display("FAIL busy_dout_lo: got %h required %h", d, m_dout_lo); end
   endtask

   task automatic test_byte_select();
      logic [31:0] d;
      int l;
      wr(8'h08, 32'h11223344, 4'hF);
      wr(8'h08, 32'hAABBCCDD, 4'b0010);
      m_key_lo = 32'h1122CC44;
      rd(8'h08, d, l);
      checks++;
      if (d !== 32'h1122CC44) begin errors++; $display("FAIL bytesel: got %h required 1122cc44", d); end
      wb_xfer(1'b0, 32'h3000_0100, 32'h0, 4'h0, d, l);
      checks++;
      if (l !== -1) begin errors++; $display("FAIL out_of_window: got ack lat=%0d required no ack", l); end
      wr(8'h20, 32'hDEADBEEF, 4'hF);
      rd(8'h20, d, l);
      checks++;
      if (d !== 32'h0 || l !== 1) begin
         errors++; $display("FAIL unmapped: got %h lat=%0d required 00000000 lat=1", d, l);
      end
      wr(8'h18, 32'h12345678, 4'hF);
      rd(8'h18, d, l);
      checks++;
      if (d !== m_dout_lo) begin errors++; $display("FAIL dout_ro: got %h required %h", d, m_dout_lo); end
   endtask

   task automatic test_back_to_back();
      logic exp_ack;
      @(negedge clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_sel = 4'h0;
      i_wb_addr = BASE | 32'h08;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         exp_ack = (i % 2 == 0);
         checks++;
         if (o_wb_ack !== exp_ack || o_wb_data !== (exp_ack ? m_key_lo : 32'h0)) begin
            errors++;
            $display("FAIL held_stb cycle %0d: got ack=%b data=%h required ack=%b data=%h",
                     i, o_wb_ack, o_wb_data, exp_ack, exp_ack ? m_key_lo : 32'h0);
         end
      end
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_random();
      logic [31:0] d, v;
      logic [3:0]  s;
      logic        dec;
      int l, target, n;
      bit ok;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(2, 6);
         for (int w = 0; w < n; w++) begin
            v = $urandom;
            s = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 3))
               0: begin wr(8'h08, v, s); m_key_lo = byte_merge(m_key_lo, v, s); end
               1: begin wr(8'h0C, v, s); m_key_hi = byte_merge(m_key_hi, v, s); end
               2: begin wr(8'h10, v, s); m_din_lo = byte_merge(m_din_lo, v, s); end
               default: begin wr(8'h14, v, s); m_din_hi = byte_merge(m_din_hi, v, s); end
            endcase
         end
         dec = 1'($urandom_range(0, 1));
         core_result = {$urandom, $urandom};
         core_lat = $urandom_range(3, 25);
         target = done_pulses + 1;
         wr(8'h00, {30'd0, dec, 1'b1}, 4'h1);
         m_dec = dec;
         wait_done(target, ok);
         m_dout_lo = core_result[31:0];
         m_dout_hi = core_result[63:32];
         checks++;
         if (!ok || seen_key !== {m_key_hi, m_key_lo} || seen_data !== {m_din_hi, m_din_lo} || seen_dec !== m_dec) begin
            errors++;
            $display("FAIL rand_operands it=%0d: got done=%b key=%h din=%h dec=%b required 1 %h %h %b", it, ok,
                     seen_key, seen_data, seen_dec, {m_key_hi, m_key_lo}, {m_din_hi, m_din_lo}, m_dec);
         end
         exp_q.push_back(m_dout_lo);
         exp_q.push_back(m_dout_hi);
         exp_q.push_back(32'h2);
         exp_q.push_back({30'd0, m_dec, 1'b0});
         for (int k = 0; k < 4; k++) begin
            rd((k == 0) ? 8'h18 : (k == 1) ? 8'h1C : (k == 2) ? 8'h04 : 8'h00, d, l);
            v = exp_q.pop_front();
            checks++;
            if (d !== v) begin errors++; $display("FAIL rand_read it=%0d k=%0d: got %h required %h", it, k, d, v); end
         end
         if ($urandom_range(0, 1) == 1) begin
            wr(8'h04, 32'h2, 4'h1);
            rd(8'h04, d, l);
            checks++;
            if (d !== 32'h0) begin errors++; $display("FAIL rand_w1c it=%0d: got %h required 00000000", it, d); end
         end
      end
   endtask

   task automatic collide_done(input logic [31:0] w1c_val, input logic [63:0] res);
      @(negedge clk);
      i_des_done = 1'b1; i_des_result = res;
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_sel = 4'hF;
      i_wb_addr = BASE | 32'h04; i_wb_data = w1c_val;
      @(posedge clk); #1;
      i_des_done = 1'b0; i_des_result = '0;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      @(posedge clk);
   endtask

   task automatic test_w1c_collision();
      logic [31:0] d, exp_status;
      int l;
      logic exp_irq;
`ifdef DES_WB_IRQ_EN
      int target;
      bit ok;
      core_lat = 10;
      core_result = 64'h0BAD_F00D_CAFE_0001;
      target = done_pulses + 1;
      wr(8'h00, 32'h5, 4'hF);
      wait_done(target, ok);
      @(negedge clk);
      checks++;
      if (!ok || o_irq !== 1'b1) begin errors++; $display("FAIL irq_set: got done=%b irq=%b required 1/1", ok, o_irq); end
      rd(8'h04, d, l);
      checks++;
      if (d !== 32'h6) begin errors++; $display("FAIL irq_status: got %h required 00000006", d); end
      wr(8'h04, 32'h4, 4'hF);
      checks++;
      if (o_irq !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b required 0", o_irq); end
      exp_status = 32'h6; exp_irq = 1'b1;
      m_dec = 1'b0;
      auto_core = 1'b0;
      wr(8'h00, 32'h5, 4'hF);
      repeat (3) @(negedge clk);
      collide_done(32'h4, 64'h1111_2222_3333_4444);
`else
      wr(8'h00, 32'h4, 4'hF);
      rd(8'h00, d, l);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL ctrl_irq_en_dropped: got %h required 00000000", d); end
      exp_status = 32'h2; exp_irq = 1'b0;
      m_dec = 1'b0;
      auto_core = 1'b0;
      wr(8'h00, 32'h1, 4'hF);
      repeat (3) @(negedge clk);
      collide_done(32'h6, 64'h1111_2222_3333_4444);
`endif
      m_dout_lo = 32'h33334444; m_dout_hi = 32'h11112222;
      rd(8'h04, d, l);
      checks++;
      if (d !== exp_status || o_irq !== exp_irq) begin
         errors++; $display("FAIL w1c_collision: got status=%h irq=%b required %h/%b", d, o_irq, exp_status, exp_irq);
      end
      rd(8'h1C, d, l);
      checks++;
      if (d !== m_dout_hi) begin errors++; $display("FAIL collision_dout_hi: got %h required %h", d, m_dout_hi); end
      // a completion pulse while idle must not disturb the result
      @(negedge clk); i_des_done = 1'b1; i_des_result = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk); i_des_done = 1'b0; i_des_result = '0;
      rd(8'h18, d, l);
      checks++;
      if (d !== m_dout_lo) begin errors++; $display("FAIL idle_done_ignored: got %h required %h", d, m_dout_lo); end
      auto_core = 1'b1;
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] d;
      int l, p0;
      auto_core = 1'b0;
      wr(8'h00, 32'h1, 4'hF);
      repeat (4) @(negedge clk);
      p0 = start_pulses;
      apply_reset();
      @(negedge clk); i_des_done = 1'b1; i_des_result = 64'hDEAD_BEEF_0123_4567;
      @(negedge clk); i_des_done = 1'b0; i_des_result = '0;
      repeat (5) @(negedge clk);
      rd(8'h04, d, l);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h required 00000000", d); end
      rd(8'h18, d, l);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_dout_lo: got %h required 00000000", d); end
      rd(8'h1C, d, l);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_dout_hi: got %h required 00000000", d); end
      checks++;
      if (start_pulses !== p0 || o_des_start !== 1'b0) begin
         errors++; $display("FAIL rst_no_restart: got extra starts=%0d start=%b required 0/0", start_pulses - p0, o_des_start);
      end
      auto_core = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
      i_wb_sel = '0; i_wb_addr = '0; i_wb_data = '0;
      test_reset();
      test_des_vector();
      test_busy_ignore();
      test_byte_select();
      test_back_to_back();
      test_random();
      test_w1c_collision();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
